vga_bounce_box: RTL
===================

# vga_bounce_box

Pixel-generation stage sitting directly downstream of the VGA sync/coordinate decoder. It consumes the decoder's h_sync, v_sync, DE, x_pixel and y_pixel, and draws a 640x480 frame: a one-pixel white screen border, a dark background, and a solid square that moves and bounces off the screen edges once per frame. It drives the 4-bit-per-channel RGB ports and pipeline-aligned sync outputs to the connector. It replaces the static colour generator in the top-level controller.

## Interface
- BOX_SIZE, 32: square side length in pixels; must be at most 480.
- STEP, 2: pixels moved per axis per update; must be at least 1 and less than BOX_SIZE.
- FRAME_DIV, 1: number of frames per position update; must be at least 1.
- clk  in  1  system clock, 4x the pixel rate (same clock as the decoder). One clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high reset.
- h_sync_in  in  1  horizontal sync from the decoder, active low.
- v_sync_in  in  1  vertical sync from the decoder, active low.
- DE  in  1  display enable from the decoder.
- x_pixel  in  10  column, 0..639. Valid only while DE=1; may be Z otherwise.
- y_pixel  in  10  row, 0..479. Valid only while DE=1; may be Z otherwise.
- pause  in  1  level input. When 1, freezes box motion. Synchronous to clk.
- h_sync  out  1  h_sync_in delayed by 2 clk cycles.
- v_sync  out  1  v_sync_in delayed by 2 clk cycles.
- red_port, green_port, blue_port  out  4 each  pixel colour.

## Operation
- **Pixel path.** Never use x_pixel or y_pixel when DE=0; gate them to 0 before any compare, so Z never propagates.
- **Colour priority**, in order:
  1. DE=0 gives 000.
  2. Border pixel (x=0, x=639, y=0 or y=479) gives FFF.
  3. Pixel inside the box (box_x ≤ x < box_x+BOX_SIZE and box_y ≤ y < box_y+BOX_SIZE) gives palette[color_idx].
  4. Otherwise background 002.
- **Palette.** Index 0 = F00, 1 = 0F0, 2 = 00F, 3 = FF0.
- **Frame tick.** frame_tick is a one-cycle pulse on the falling edge of v_sync_in, detected against a registered copy of v_sync_in.
- **Frame divider.** frame_cnt counts 0..FRAME_DIV-1, advances on each frame_tick and wraps. An update occurs on a frame_tick where frame_cnt = FRAME_DIV-1.
- **FSM** (states ST_RUN and ST_PAUSE):
  - ST_RUN goes to ST_PAUSE when pause=1.
  - ST_PAUSE goes to ST_RUN when pause=0.
  - Updates and frame_cnt advancement happen only in ST_RUN with pause=0 on that cycle. A frame_tick coinciding with pause=1 is discarded.
- **Motion, x axis** (y is identical, using 480):
  - Limit is XMAX = 640-BOX_SIZE.
  - Moving right: if box_x+STEP ≥ XMAX, set box_x = XMAX, set dir_x = left, flag a bounce. Otherwise box_x += STEP.
  - Moving left: if box_x ≤ STEP, set box_x = 0, set dir_x = right, flag a bounce. Otherwise box_x -= STEP.
  - Use 11-bit intermediates for box_x+STEP; no wrap is permitted.
- **Bounce colour.** color_idx increments by exactly 1 (mod 4) on any update with a bounce on either or both axes. A corner hit advances it by one only.
- **No tearing.** Position changes only at frame_tick, which falls inside vertical blanking.
- **Reset values:**
  - Outputs: red_port, green_port and blue_port = 0; h_sync and v_sync = 1.
  - Motion state: box_x = (640-BOX_SIZE)/2 (304 at default), box_y = (480-BOX_SIZE)/2 (224 at default), dir right/down, color_idx 0, frame_cnt 0, FSM ST_RUN.
  - Edge detector: v_sync_in copy = 1.
- **Reset mid-frame.** Every register returns to its reset value immediately (asynchronously). After release, operation resumes at the next frame_tick.

## Timing
- **Pipeline stage 1 (registered):** DE, border hit, box hit, colour index, h_sync_in, v_sync_in.
- **Pipeline stage 2 (registered):** RGB, h_sync, v_sync.
- **Latency.** Pixel inputs to RGB is exactly 2 clk. Sync inputs to sync outputs is exactly 2 clk. Colour and sync stay mutually aligned.
- **Position visibility.** A position update made on a frame_tick affects pixels sampled from the next clk onward; the first visible effect is row 0 of the next frame.
- **pause** is sampled every clk; there is no handshake.

## Structure
- **Package vga_pkg** holds:
  - H_ACTIVE = 640, V_ACTIVE = 480;
  - typedef struct rgb_t {red, green, blue} of 4 bits each;
  - the PALETTE array of four rgb_t;
  - BG_COLOR, BORDER_COLOR;
  - typedef enum state_t {ST_RUN, ST_PAUSE}.
- **Sub-module box_motion_ctrl** holds the edge detector, frame divider, FSM, box_x/box_y/direction registers and color_idx. Its outputs are box_x, box_y and color_idx. vga_bounce_box instantiates it and the two-stage pixel pipeline.

## Test plan
- **Reset.** Assert reset mid-line. Required: RGB = 000, h_sync = v_sync = 1, box at (304,224), color_idx 0, all within the same cycle.
- **Latency.** Drive DE=1, x=0, y=5. Required: RGB = FFF exactly 2 clk later. Toggle h_sync_in and check the h_sync edge also lands 2 clk later.
- **Motion.** After one v_sync_in falling edge, the box is at (306,226). Pixel (306,226) gives F00. Pixel (305,226) gives 002.
- **Right bounce.** Preload box_x = 607 moving right. After a tick, box_x = 608 and dir = left. color_idx = 1, so the inside pixel is 0F0. After the next tick, box_x = 606.
- **Corner.** Place the box at x=607, y=447, both axes moving positive. After a tick, the box is at (608,448), both directions flipped, and color_idx advanced by exactly 1.
- **Pause and divider.** With pause=1 across three frame edges, the box is unchanged. Release pause and set FRAME_DIV=3: the box moves only on every third frame edge.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared geometry, colour types and FSM states for the VGA pixel-generation stage.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb_t;

  localparam rgb_t PALETTE [0:3] = '{
    '{red: 4'hF, green: 4'h0, blue: 4'h0},
    '{red: 4'h0, green: 4'hF, blue: 4'h0},
    '{red: 4'h0, green: 4'h0, blue: 4'hF},
    '{red: 4'hF, green: 4'hF, blue: 4'h0}
  };

  localparam rgb_t BG_COLOR     = '{red: 4'h0, green: 4'h0, blue: 4'h2};
  localparam rgb_t BORDER_COLOR = '{red: 4'hF, green: 4'hF, blue: 4'hF};

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_t;

endpackage

// File: rtl/vga_bounce_box_motion_ctrl.sv
// Box position/direction/colour state, advanced on the falling edge of v_sync_in
// (inside vertical blanking), divided by FRAME_DIV and frozen while paused.
module box_motion_ctrl
  import vga_pkg::*;
#(
  parameter int BOX_SIZE  = 32,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       v_sync_in,
  input  logic       pause,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic [1:0] color_idx
);

  localparam int XMAX  = H_ACTIVE - BOX_SIZE;
  localparam int YMAX  = V_ACTIVE - BOX_SIZE;
  localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

  logic             vs_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [9:0]       box_x_q, box_x_d, box_y_q, box_y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [1:0]       color_idx_q, color_idx_d;
  logic             frame_tick, run_tick, update, bounce_x, bounce_y;
  logic [10:0]      sum_x, sum_y;

  assign frame_tick = vs_q & ~v_sync_in;
  // A tick landing while paused (or in the cycle pause drops) is discarded entirely.
  assign run_tick   = frame_tick && (state_q == ST_RUN) && !pause;
  assign update     = run_tick && (frame_cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (pause)  state_d = ST_PAUSE;
      ST_PAUSE: if (!pause) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (run_tick) frame_cnt_d = update ? '0 : frame_cnt_q + CNT_W'(1);
  end

  // dir = 0 means right/down; sums are 11 bits so the limit compare cannot wrap.
  always_comb begin
    sum_x    = {1'b0, box_x_q} + 11'(STEP);
    box_x_d  = box_x_q;
    dir_x_d  = dir_x_q;
    bounce_x = 1'b0;
    if (update) begin
      if (!dir_x_q) begin
        if (sum_x >= 11'(XMAX)) begin
          box_x_d  = 10'(XMAX);
          dir_x_d  = 1'b1;
          bounce_x = 1'b1;
        end else begin
          box_x_d = sum_x[9:0];
        end
      end else if (box_x_q <= 10'(STEP)) begin
        box_x_d  = '0;
        dir_x_d  = 1'b0;
        bounce_x = 1'b1;
      end else begin
        box_x_d = box_x_q - 10'(STEP);
      end
    end
  end

  always_comb begin
    sum_y    = {1'b0, box_y_q} + 11'(STEP);
    box_y_d  = box_y_q;
    dir_y_d  = dir_y_q;
    bounce_y = 1'b0;
    if (update) begin
      if (!dir_y_q) begin
        if (sum_y >= 11'(YMAX)) begin
          box_y_d  = 10'(YMAX);
          dir_y_d  = 1'b1;
          bounce_y = 1'b1;
        end else begin
          box_y_d = sum_y[9:0];
        end
      end else if (box_y_q <= 10'(STEP)) begin
        box_y_d  = '0;
        dir_y_d  = 1'b0;
        bounce_y = 1'b1;
      end else begin
        box_y_d = box_y_q - 10'(STEP);
      end
    end
  end

  // A corner hit bounces both axes but still advances the colour only once.
  always_comb begin
    color_idx_d = color_idx_q;
    if (update && (bounce_x || bounce_y)) color_idx_d = color_idx_q + 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q        <= 1'b1;
      state_q     <= ST_RUN;
      frame_cnt_q <= '0;
      box_x_q     <= 10'((H_ACTIVE - BOX_SIZE) / 2);
      box_y_q     <= 10'((V_ACTIVE - BOX_SIZE) / 2);
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      color_idx_q <= 2'd0;
    end else begin
      vs_q        <= v_sync_in;
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      color_idx_q <= color_idx_d;
    end
  end

  assign box_x     = box_x_q;
  assign box_y     = box_y_q;
  assign color_idx = color_idx_q;

endmodule

// File: rtl/vga_bounce_box.sv
// Two-stage pixel pipeline: border / bouncing box / background colour, with syncs
// delayed by the same 2 clk so colour and sync stay aligned at the connector.
module vga_bounce_box
  import vga_pkg::*;
#(
  parameter int BOX_SIZE  = 32,
  parameter int STEP      = 2,
  parameter int FRAME_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic       DE,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  input  logic       pause,
  output logic       h_sync,
  output logic       v_sync,
  output logic [3:0] red_port,
  output logic [3:0] green_port,
  output logic [3:0] blue_port
);

  logic [9:0]  box_x, box_y;
  logic [1:0]  color_idx;
  logic [9:0]  x_g, y_g;
  logic        border_d, box_hit_d;
  logic        de_q, border_q, box_hit_q, hs_q, vs_q;
  logic [1:0]  cidx_q;
  rgb_t        rgb_d, rgb_q;
  logic        h_sync_q, v_sync_q;

  box_motion_ctrl #(
    .BOX_SIZE (BOX_SIZE),
    .STEP     (STEP),
    .FRAME_DIV(FRAME_DIV)
  ) u_motion (
    .clk      (clk),
    .reset    (reset),
    .v_sync_in(v_sync_in),
    .pause    (pause),
    .box_x    (box_x),
    .box_y    (box_y),
    .color_idx(color_idx)
  );

  // Coordinates may float outside active video; zero them before any compare.
  assign x_g = DE ? x_pixel : '0;
  assign y_g = DE ? y_pixel : '0;

  assign border_d  = (x_g == 10'd0) || (x_g == 10'(H_ACTIVE - 1)) ||
                     (y_g == 10'd0) || (y_g == 10'(V_ACTIVE - 1));
  assign box_hit_d = (x_g >= box_x) && ({1'b0, x_g} < ({1'b0, box_x} + 11'(BOX_SIZE))) &&
                     (y_g >= box_y) && ({1'b0, y_g} < ({1'b0, box_y} + 11'(BOX_SIZE)));

  always_comb begin
    rgb_d = BG_COLOR;
    if (!de_q)          rgb_d = '0;
    else if (border_q)  rgb_d = BORDER_COLOR;
    else if (box_hit_q) rgb_d = PALETTE[cidx_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q      <= 1'b0;
      border_q  <= 1'b0;
      box_hit_q <= 1'b0;
      cidx_q    <= 2'd0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      rgb_q     <= '0;
      h_sync_q  <= 1'b1;
      v_sync_q  <= 1'b1;
    end else begin
      de_q      <= DE;
      border_q  <= border_d;
      box_hit_q <= box_hit_d;
      cidx_q    <= color_idx;
      hs_q      <= h_sync_in;
      vs_q      <= v_sync_in;
      rgb_q     <= rgb_d;
      h_sync_q  <= hs_q;
      v_sync_q  <= vs_q;
    end
  end

  assign red_port   = rgb_q.red;
  assign green_port = rgb_q.green;
  assign blue_port  = rgb_q.blue;
  assign h_sync     = h_sync_q;
  assign v_sync     = v_sync_q;

endmodule
